pc_ras_unit: RTL
================

Name: pc_ras_unit

Overview:
Parametrised next-generation program counter for the LegV8 datapath fetch stage. It keeps the hold/increment/absolute/PC-relative modes and adds stall, call/return modes backed by a return-address stack (RAS), and overflow/underflow status. It drives the instruction-memory address and PC+4 to the link-register write path.

Parameters:
WIDTH, 64, PC/address width in bits.
RAS_DEPTH, 4, number of return-address stack entries (power of 2, >=2).
RESET_VECTOR, 0, PC value loaded on reset.
STEP, 4, sequential increment (bytes per instruction).

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
stall  input  1  1 = freeze PC and RAS this cycle, ps ignored.
ps  input  3  PC select mode; encoding under Behaviour.
in  input  WIDTH  absolute target, or signed word offset for relative modes.
pc  output  WIDTH  current PC (registered).
pc4  output  WIDTH  pc + STEP (combinational).
ras_empty  output  1  RAS holds 0 entries.
ras_full  output  1  RAS holds RAS_DEPTH entries.
ras_ovf  output  1  sticky: a push occurred while full.
ras_unf  output  1  sticky: a pop occurred while empty.
misalign  output  1  target low 2 bits nonzero (PC_ALIGN_CHECK_EN only, else 0).

Behaviour:
- Reset (reset=0, async): pc=RESET_VECTOR, RAS count=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0, misalign=0. Registers update only on rising clock edge after reset released.
- pc4 = pc + STEP; rel = pc4 + (in << 2); all arithmetic modulo 2^WIDTH, no carry-out.
- ps: 000 hold; 001 pc<=pc4; 010 pc<=in; 011 pc<=rel; 100 call-rel: push pc4, pc<=rel; 101 call-abs: push pc4, pc<=in; 110 return: pc<=pop; 111 reserved, treated as hold.
- One-cycle latency: new pc visible the cycle after the selecting edge; push/pop take effect on same edge.
- RAS is circular: top pointer wraps modulo RAS_DEPTH; count saturates at RAS_DEPTH.
- Push when full: overwrite oldest entry, count stays RAS_DEPTH, set ras_ovf.
- Pop when empty: pc<=in (fallback target), count stays 0, set ras_unf; entries untouched.
- Pop then push across consecutive cycles behaves as independent operations; only one op per cycle.
- stall=1 overrides all modes: pc, RAS, count, flags unchanged.
- Sticky flags clear only on reset.
- Reset mid-operation: immediate async return to reset values; RAS contents undefined but unreachable (count=0).

Optional Feature:
PC_ALIGN_CHECK_EN: when defined, any non-sequential next-PC (modes 010,011,100,101,110) with bits[1:0]!=0 loads target with bits[1:0] forced to 00 and pulses misalign high for the cycle after the edge (registered, cleared next non-stalled edge). When undefined, targets load unmodified and misalign is tied 0.

Decomposition:
- Package pc_pkg: ps encoding constants (PS_HOLD, PS_INC, PS_ABS, PS_REL, PS_CALL_REL, PS_CALL_ABS, PS_RET), default STEP.
- Sub-module ras_stack: circular LIFO with push/pop/data, count, full/empty, overflow/underflow pulses; parametrised WIDTH, RAS_DEPTH.

Test Plan:
- Reset low, release, ps=001 x3 -> pc 0,4,8,12; pc4 = pc+4 each cycle.
- pc=0x100, ps=011, in=-2 (two's complement) -> pc=0xFC; in=0x3 -> pc=0x110.
- pc=0x40, ps=100, in=4 -> pc=0x54, RAS top=0x44; then ps=110 -> pc=0x44, ras_empty=1.
- RAS_DEPTH=4: five call-abs pushes (pc4 values A..E) then five returns -> pops E,D,C,B then underflow: pc=in, ras_ovf=1, ras_unf=1.
- stall=1 with ps=100 for 3 cycles -> pc, RAS count, flags unchanged; stall=0 -> call executes once.
- pc=0xFFFF_FFFF_FFFF_FFFC, ps=001 -> pc=0 (wrap); PC_ALIGN_CHECK_EN: ps=010, in=0x102 -> pc=0x100, misalign=1 one cycle.

Source files
------------

// File: rtl/pc_ras_unit_pkg.sv
// pc_pkg: shared definitions for the pc_ras_unit fetch-stage program counter.
// Contents: PC-select (ps) encodings and default parameter values.
package pc_pkg;

  localparam logic [2:0] PS_HOLD     = 3'b000;  // keep current pc
  localparam logic [2:0] PS_INC      = 3'b001;  // pc <= pc + STEP
  localparam logic [2:0] PS_ABS      = 3'b010;  // pc <= in
  localparam logic [2:0] PS_REL      = 3'b011;  // pc <= pc4 + (in << 2)
  localparam logic [2:0] PS_CALL_REL = 3'b100;  // push pc4, pc <= rel
  localparam logic [2:0] PS_CALL_ABS = 3'b101;  // push pc4, pc <= in
  localparam logic [2:0] PS_RET      = 3'b110;  // pc <= pop (or in when empty)
  localparam logic [2:0] PS_RSVD     = 3'b111;  // reserved, behaves as hold

  localparam int unsigned DEFAULT_STEP      = 32'd4;
  localparam int unsigned DEFAULT_RAS_DEPTH = 32'd4;

endpackage

// File: rtl/pc_ras_unit_if.sv
// pc_ras_unit_if: fetch-stage PC control/status bundle.
//   stall, ps, in          : control from the pipeline (master -> slave)
//   pc, pc4                : current PC and PC+STEP (slave -> master)
//   ras_empty, ras_full    : return-address stack occupancy
//   ras_ovf, ras_unf       : sticky push-while-full / pop-while-empty
//   misalign               : misaligned non-sequential target seen
interface pc_ras_unit_if #(
  parameter int unsigned WIDTH = 32'd64
);
  logic             stall;
  logic [2:0]       ps;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc4;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_ovf;
  logic             ras_unf;
  logic             misalign;

  modport master (
    output stall, ps, in,
    input  pc, pc4, ras_empty, ras_full, ras_ovf, ras_unf, misalign
  );

  modport slave (
    input  stall, ps, in,
    output pc, pc4, ras_empty, ras_full, ras_ovf, ras_unf, misalign
  );
endinterface

// File: rtl/pc_ras_unit_ras_stack.sv
// ras_stack: circular return-address LIFO.
//   clock, reset (async active-low)
//   i_push/i_data : push a return address; when full the oldest entry is overwritten
//   i_pop         : pop top entry (ignored when empty)
//   o_data        : current top entry (valid when not empty)
//   o_full/o_empty: occupancy; o_ovf/o_unf: single-cycle push-while-full / pop-while-empty
// The caller guarantees push and pop are never requested together.
module ras_stack #(
  parameter int unsigned WIDTH     = 32'd64,
  parameter int unsigned RAS_DEPTH = 32'd4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_ovf,
  output logic             o_unf
);
  localparam int unsigned PW         = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]    r_top;    // next free slot; wraps, so a full push lands on the oldest entry
  logic [PW:0]      r_count;
  logic [PW-1:0]    w_top_m1;

  assign w_top_m1 = r_top - PW'(1);
  assign o_data   = r_mem[w_top_m1];
  assign o_full   = (r_count == FULL_COUNT);
  assign o_empty  = (r_count == (PW+1)'(0));
  assign o_ovf    = i_push & o_full;
  assign o_unf    = i_pop & o_empty;

  // Top pointer and occupancy; count saturates at RAS_DEPTH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_top <= r_top + PW'(1);
      if (!o_full) begin
        r_count <= r_count + (PW+1)'(1);
      end
    end else if (i_pop && !o_empty) begin
      r_top   <= w_top_m1;
      r_count <= r_count - (PW+1)'(1);
    end
  end

  // Entry storage; contents need no reset because count=0 makes them unreachable.
  always_ff @(posedge clock) begin
    if (i_push) begin
      r_mem[r_top] <= i_data;
    end
  end
endmodule

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: LegV8 fetch-stage program counter with return-address stack.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : pc_ras_unit_if.slave (stall, ps, in -> pc, pc4, RAS status, misalign)
// Optional build macro PC_ALIGN_CHECK_EN: non-sequential targets with nonzero
// bits[1:0] are forced to word alignment and misalign pulses for one cycle.
// Without it targets load unmodified and misalign is tied low.
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH        = 32'd64,
  parameter int unsigned       RAS_DEPTH    = DEFAULT_RAS_DEPTH,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned       STEP         = DEFAULT_STEP
) (
  input  logic           clock,
  input  logic           reset,
  pc_ras_unit_if.slave   bus
);
  logic [WIDTH-1:0] r_pc;
  logic             r_ovf;
  logic             r_unf;
  logic [WIDTH-1:0] w_pc4;
  logic [WIDTH-1:0] w_rel;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_next_pc;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_ras_data;
  logic             w_ras_full;
  logic             w_ras_empty;
  logic             w_ovf_pulse;
  logic             w_unf_pulse;

  assign w_pc4 = r_pc + WIDTH'(STEP);
  // The word offset is scaled to bytes; the top two bits fall off (modulo 2^WIDTH).
  assign w_rel = w_pc4 + {bus.in[WIDTH-3:0], 2'b00};

  // Mode decode: candidate target and stack operation; stall suppresses stack ops.
  always_comb begin
    w_target = r_pc;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    case (bus.ps)
      PS_HOLD:     w_target = r_pc;
      PS_INC:      w_target = w_pc4;
      PS_ABS:      w_target = bus.in;
      PS_REL:      w_target = w_rel;
      PS_CALL_REL: begin w_target = w_rel;  w_push = ~bus.stall; end
      PS_CALL_ABS: begin w_target = bus.in; w_push = ~bus.stall; end
      PS_RET: begin
        w_pop    = ~bus.stall;
        w_target = w_ras_empty ? bus.in : w_ras_data;  // empty stack falls back to in
      end
      default:     w_target = r_pc;
    endcase
  end

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc4),
    .o_data  (w_ras_data),
    .o_full  (w_ras_full),
    .o_empty (w_ras_empty),
    .o_ovf   (w_ovf_pulse),
    .o_unf   (w_unf_pulse)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic w_nonseq;
  logic w_mis;
  logic r_mis;

  assign w_nonseq  = (bus.ps != PS_HOLD) && (bus.ps != PS_INC) && (bus.ps != PS_RSVD);
  assign w_mis     = w_nonseq & (w_target[1:0] != 2'b00);
  assign w_next_pc = w_mis ? {w_target[WIDTH-1:2], 2'b00} : w_target;
  assign bus.misalign = r_mis;

  // Misalign flag: set for the cycle after a corrected target, cleared on the next live edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mis <= 1'b0;
    end else if (!bus.stall) begin
      r_mis <= w_mis;
    end else begin
      r_mis <= r_mis;
    end
  end
`else
  assign w_next_pc    = w_target;
  assign bus.misalign = 1'b0;
`endif

  // PC register and sticky stack status; a stall freezes everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc  <= RESET_VECTOR;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (!bus.stall) begin
      r_pc  <= w_next_pc;
      r_ovf <= r_ovf | w_ovf_pulse;
      r_unf <= r_unf | w_unf_pulse;
    end else begin
      r_pc  <= r_pc;
      r_ovf <= r_ovf;
      r_unf <= r_unf;
    end
  end

  assign bus.pc        = r_pc;
  assign bus.pc4       = w_pc4;
  assign bus.ras_empty = w_ras_empty;
  assign bus.ras_full  = w_ras_full;
  assign bus.ras_ovf   = r_ovf;
  assign bus.ras_unf   = r_unf;
endmodule
